clk_enable_gen: RTL and testbench
=================================

Name: clk_enable_gen

Overview:
- Parametrised, multi-channel fractional clock-enable generator driven from the PLL output clock.
- Qualifies the PLL lock signal: synchronises it, then requires it stable for a programmable number of cycles.
- Then runs one phase accumulator per channel, each with a runtime-programmable increment.
- Provides any number of derived tick rates (f_tick = f_clk * inc / 2^ACC_W) without extra PLLs, and a clean "ready" for downstream reset release.

Parameters:
- CHANNELS, 2, number of independent tick channels (1..8).
- ACC_W, 24, phase accumulator and increment width in bits (4..32).
- LOCK_CYCLES, 1024, consecutive synchronised lock-high cycles required before ready (>=1).
- INC_RESET, 0, increment loaded into every channel on reset.

Ports:
- clk  in  1  system clock (PLL output).
- rst  in  1  synchronous, active-high reset.
- lock  in  1  PLL lock; asynchronous to clk.
- wr_en  in  1  increment write strobe.
- wr_ch  in  max(1,clog2(CHANNELS))  channel index for the write.
- wr_inc  in  ACC_W  new increment value.
- sync  in  1  phase-align strobe; clears all accumulators.
- ready  out  1  high while lock is qualified and the generator is running.
- tick  out  CHANNELS  per-channel one-cycle enable pulses.

Behaviour:
Reset and interface:
- One clock; reset is synchronous and active-high.
- On rst all of the following hold on the next edge:
  - sync flops = 0, state = WAIT_LOCK, lock counter = 0.
  - all accumulators = 0, all increments = INC_RESET.
  - ready = 0, tick = 0.
- rst has priority over every other input, including mid-qualification and mid-RUN.

Lock synchroniser:
- Two flip-flop synchroniser lock -> lock_s.
- lock_s follows lock with 2-cycle latency.

State machine:
- WAIT_LOCK: counter = 0, ready = 0, tick = 0, accumulators held at 0. lock_s = 1 -> QUALIFY with counter = 1.
- QUALIFY: lock_s = 0 -> WAIT_LOCK with counter cleared. Otherwise counter increments. When counter == LOCK_CYCLES -> RUN.
- RUN: ready = 1 and accumulators advance. lock_s = 0 -> WAIT_LOCK on the next edge, with ready = 0, tick = 0 and all accumulators cleared in that same edge. Increments are retained.

Timing of ready:
- With lock held high from before edge E0, ready is 1 after edge E0 + 2 + LOCK_CYCLES.
- Any lock_s low during QUALIFY restarts qualification from zero.

Accumulator, per channel c, each RUN cycle:
- {carry, acc[c]} <= acc[c] + inc[c], computed at ACC_W+1 bits; acc wraps modulo 2^ACC_W.
- tick[c] <= carry, so tick is registered and high exactly one cycle per overflow.
- inc = 0: tick never asserts.
- inc = 2^ACC_W - 1: tick asserts on every cycle except one per 2^ACC_W.
- Outside RUN: tick = 0.

Increment writes:
- wr_en writes inc[wr_ch] <= wr_inc in any state.
- Takes effect from the next cycle: an accumulation in the same cycle as the write uses the old value.
- wr_ch >= CHANNELS: write ignored.

sync:
- In RUN: all acc <= 0 and all tick <= 0 on that edge, regardless of carry; accumulation resumes on the next cycle.
- Simultaneous sync and wr_en: both take effect.
- sync outside RUN: no effect.

Outputs:
- ready and tick are registered, with no combinational path from any input.

Test Plan:
1. LOCK_CYCLES=16, rst for 3 cycles, then lock=1 constant -> ready=0 through edge E0+17, ready=1 from edge E0+18 onward; tick=0 throughout qualification.
2. lock=1 for 10 cycles, low for 1 cycle, then high (LOCK_CYCLES=16) -> qualification restarts; ready rises 2+16 edges after the second rising of lock.
3. ACC_W=4, CHANNELS=2, inc0=4, inc1=3 written before lock -> after ready:
   - tick[0] on cycles 4, 8, 12, ... counted from the first RUN cycle.
   - tick[1] on cycles 6, 11, 16, ... (acc1 sequence 3, 6, 9, 12, 15, 2, ...).
   - Over 48 cycles: 12 tick[0], 9 tick[1].
4. In RUN, write inc0 from 4 to 8 in the same cycle acc0 overflows -> that cycle's tick still follows inc=4; afterwards tick[0] every 2 cycles. Write with wr_ch=3 when CHANNELS=2 -> no increment changes.
5. In RUN with acc0=12 and inc0=4, assert sync -> no tick on the following edge, acc0=0; next tick exactly 4 cycles later; all channels realigned.
6. Drop lock in RUN -> ready=0 and tick=0 two edges after the synchroniser sees it low. Assert rst mid-RUN -> all outputs 0 next edge and increments return to INC_RESET. inc=0 on any channel -> no tick over 1000 cycles.

Source files
------------

// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator. Qualifies the PLL lock,
// then runs one phase accumulator per channel whose carry-out is the tick.
//
// state     | meaning
// WAIT_LOCK | synchronised lock low; ready, ticks and accumulators held at 0
// QUALIFY   | counting consecutive synchronised lock-high cycles
// RUN       | ready high, accumulators advancing
module clk_enable_gen #(
    parameter int CHANNELS    = 2,
    parameter int ACC_W       = 24,
    parameter int LOCK_CYCLES = 1024,
    parameter int INC_RESET   = 0,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CNT_W      = $clog2(LOCK_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lock,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [ACC_W-1:0]    wr_inc,
    input  logic                sync,
    output logic                ready,
    output logic [CHANNELS-1:0] tick
);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        QUALIFY,
        RUN
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    lock_cnt;
    logic [CNT_W-1:0]    lock_cnt_nxt;
    logic                lock_m;
    logic                lock_s;
    logic                advance;
    logic [ACC_W-1:0]    acc [CHANNELS];
    logic [ACC_W-1:0]    inc [CHANNELS];
    logic [CHANNELS-1:0] tick_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= lock;
            lock_s <= lock_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WAIT_LOCK;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        case (state)
            WAIT_LOCK: begin
                lock_cnt_nxt = '0;
                if (lock_s) begin
                    state_nxt    = QUALIFY;
                    lock_cnt_nxt = CNT_W'(1);
                end
            end
            QUALIFY: begin
                if (!lock_s) begin
                    state_nxt    = WAIT_LOCK;
                    lock_cnt_nxt = '0;
                end else if (lock_cnt == CNT_W'(LOCK_CYCLES)) begin
                    state_nxt = RUN;
                end else begin
                    lock_cnt_nxt = lock_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nxt    = WAIT_LOCK;
                    lock_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = WAIT_LOCK;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    // Losing lock or a sync strobe clears every accumulator on the same edge.
    assign advance = (state == RUN) && lock_s && !sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= '0;
                inc[c] <= ACC_W'(INC_RESET);
            end
            tick_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (advance) begin
                    {tick_q[c], acc[c]} <= {1'b0, acc[c]} + {1'b0, inc[c]};
                end else begin
                    acc[c]    <= '0;
                    tick_q[c] <= 1'b0;
                end
            end
            if (wr_en && (32'(wr_ch) < CHANNELS)) begin
                inc[wr_ch] <= wr_inc;
            end
        end
    end

    assign ready = (state == RUN);
    assign tick  = tick_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Bench for clk_enable_gen: scoreboard of per-edge ready/tick expectations
// plus a segment table and hand-written corner sequences.
module tb_clk_enable_gen;
    localparam int CH  = 3;
    localparam int AW  = 4;
    localparam int LC  = 16;
    localparam int MOD = 1 << AW;

    logic       clk = 1'b0;
    logic       rst;
    logic       lock;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [3:0] wr_inc;
    logic       sync;
    logic       ready;
    logic [2:0] tick;

    clk_enable_gen #(
        .CHANNELS   (CH),
        .ACC_W      (AW),
        .LOCK_CYCLES(LC),
        .INC_RESET  (0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .lock  (lock),
        .wr_en (wr_en),
        .wr_ch (wr_ch),
        .wr_inc(wr_inc),
        .sync  (sync),
        .ready (ready),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ready;
        logic [2:0] tick;
    } exp_t;

    typedef struct {
        string    name;
        int       n;
        logic     lock;
        logic     wr;
        logic [1:0] wr_ch;
        logic [3:0] wr_inc;
        int       t0;
        int       t1;
        int       t2;
        int       ready_end;
    } seg_t;

    exp_t sb_q[$];
    seg_t segs[3];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tick_cnt[CH];

    // Reference model: ready follows a run of consecutive synchronised-high
    // lock samples; each channel keeps an integer phase modulo 2^AW.
    int m_s1, m_s2, m_run_cnt;
    int m_acc[CH];
    int m_inc[CH];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_push();
        exp_t e;
        bit   adv;
        int   s;
        e = '0;
        if (rst) begin
            m_s1 = 0;
            m_s2 = 0;
            m_run_cnt = 0;
            for (int c = 0; c < CH; c++) begin
                m_acc[c] = 0;
                m_inc[c] = 0;
            end
        end else begin
            adv = (m_run_cnt >= LC + 1) && (m_s2 != 0) && !sync;
            for (int c = 0; c < CH; c++) begin
                if (adv) begin
                    s = m_acc[c] + m_inc[c];
                    e.tick[c] = (s >= MOD);
                    m_acc[c] = s % MOD;
                end else begin
                    m_acc[c] = 0;
                end
            end
            if (wr_en && (int'(wr_ch) < CH)) m_inc[wr_ch] = int'(wr_inc);
            m_run_cnt = (m_s2 != 0) ? m_run_cnt + 1 : 0;
            m_s2 = m_s1;
            m_s1 = int'(lock);
        end
        e.ready = (m_run_cnt >= LC + 1);
        sb_q.push_back(e);
    endfunction

    task automatic step();
        exp_t e;
        model_push();
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("ready", int'(ready), int'(e.ready));
        check("tick", int'(tick), int'(e.tick));
        for (int c = 0; c < CH; c++) if (tick[c]) tick_cnt[c]++;
    endtask

    // Steps until ready is seen; idx is the step number (0 = first step), -1 on timeout.
    task automatic first_ready(input int lim, output int idx);
        idx = -1;
        for (int k = 0; k < lim && idx < 0; k++) begin
            step();
            if (ready) idx = k;
        end
    endtask

    task automatic run_seg(input int i);
        tick_cnt = '{default: 0};
        lock = segs[i].lock;
        for (int k = 0; k < segs[i].n; k++) begin
            wr_en  = (k == 0) && segs[i].wr;
            wr_ch  = segs[i].wr_ch;
            wr_inc = segs[i].wr_inc;
            step();
        end
        wr_en = 1'b0;
        check({segs[i].name, "_t0"}, tick_cnt[0], segs[i].t0);
        check({segs[i].name, "_t1"}, tick_cnt[1], segs[i].t1);
        check({segs[i].name, "_t2"}, tick_cnt[2], segs[i].t2);
        check({segs[i].name, "_ready"}, int'(ready), segs[i].ready_end);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, i0, i1;
        segs[0] = '{"run48",    48,   1'b1, 1'b0, 2'd0, 4'd0,  12, 9,  0, 1};
        segs[1] = '{"zero_inc", 1000, 1'b1, 1'b0, 2'd0, 4'd0,  0,  0,  0, 1};
        segs[2] = '{"max_inc",  33,   1'b1, 1'b1, 2'd1, 4'd15, 0,  30, 0, 1};

        rst = 1'b1; lock = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_inc = '0; sync = 1'b0;
        m_s1 = 0; m_s2 = 0; m_run_cnt = 0;
        for (int c = 0; c < CH; c++) begin
            m_acc[c] = 0;
            m_inc[c] = 0;
        end
        tick_cnt = '{default: 0};

        repeat (3) step();
        check("rst_ready", int'(ready), 0);
        check("rst_tick", int'(tick), 0);
        rst = 1'b0;

        wr_en = 1'b1; wr_ch = 2'd0; wr_inc = 4'd4; step();
        wr_ch = 2'd1; wr_inc = 4'd3; step();
        wr_en = 1'b0; step();

        // Qualification from a clean start: ready first seen after step 18.
        lock = 1'b1;
        first_ready(40, idx);
        check("qual_ready_edge", idx, 18);

        // 48 RUN cycles with inc0=4, inc1=3, inc2=0.
        run_seg(0);

        // Increment write on the overflow edge uses the old increment.
        repeat (3) step();
        wr_en = 1'b1; wr_ch = 2'd0; wr_inc = 4'd8;
        step();
        check("wr_old_inc_tick0", int'(tick[0]), 1);
        wr_ch = 2'd3; wr_inc = 4'd15;
        for (int j = 1; j <= 4; j++) begin
            step();
            wr_en = 1'b0;
            check("inc8_tick0", int'(tick[0]), (j % 2 == 0) ? 1 : 0);
        end

        // sync together with a write, then sync while acc0 sits at 12.
        sync = 1'b1; wr_en = 1'b1; wr_ch = 2'd0; wr_inc = 4'd4;
        step();
        check("sync_wr_tick", int'(tick), 0);
        sync = 1'b0; wr_en = 1'b0;
        repeat (3) step();
        sync = 1'b1;
        step();
        check("sync_suppress_tick0", int'(tick[0]), 0);
        sync = 1'b0;
        i0 = -1; i1 = -1;
        for (int j = 1; j <= 8; j++) begin
            step();
            if (tick[0] && i0 < 0) i0 = j;
            if (tick[1] && i1 < 0) i1 = j;
        end
        check("sync_next_tick0", i0, 4);
        check("sync_next_tick1", i1, 6);

        // Lock loss in RUN: ready stays up while the synchroniser drains.
        lock = 1'b0;
        step();
        check("drop_ready_e0", int'(ready), 1);
        step();
        check("drop_ready_e1", int'(ready), 1);
        step();
        check("drop_ready_e2", int'(ready), 0);
        check("drop_tick_e2", int'(tick), 0);
        repeat (5) step();

        // Lock glitch during qualification restarts the count.
        lock = 1'b1;
        repeat (10) step();
        lock = 1'b0;
        step();
        lock = 1'b1;
        first_ready(40, idx);
        check("glitch_ready_edge", idx, 18);
        i0 = -1;
        for (int j = 1; j <= 6 && i0 < 0; j++) begin
            step();
            if (tick[0]) i0 = j;
        end
        check("retained_inc_tick0", i0, 4);

        // Reset mid-RUN beats a simultaneous write; increments return to 0.
        rst = 1'b1; wr_en = 1'b1; wr_ch = 2'd0; wr_inc = 4'd5;
        step();
        check("midrun_rst_ready", int'(ready), 0);
        check("midrun_rst_tick", int'(tick), 0);
        rst = 1'b0; wr_en = 1'b0;
        first_ready(40, idx);
        check("rst_requal_edge", idx, 18);

        for (int i = 1; i < 3; i++) run_seg(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
